// File: rtl/xor_cipher_ctrl_if.sv
// xor_cipher_ctrl_if: control, handshake and key/message bundle around the XOR-cipher sequencer
interface xor_cipher_ctrl_if #(parameter int DATA_SIZE = 32);
   localparam int CNT_W = $clog2(DATA_SIZE) + 1;
   logic                 iStart;
   logic                 iAbort;
   logic                 iBit_valid;
   logic [DATA_SIZE-1:0] iKey;
   logic [DATA_SIZE-1:0] iMsg;
   logic                 iSer_ready;
   logic                 oDeser_rst_n;
   logic                 oLoading;
   logic                 oKey_en;
   logic                 oMsg_en;
   logic                 oSer_bit;
   logic                 oSer_valid;
   logic                 oBusy;
   logic                 oDone;
   logic [2:0]           oState;
   logic [CNT_W-1:0]     oBit_counter;
   modport slave (
      input  iStart, iAbort, iBit_valid, iKey, iMsg, iSer_ready,
      output oDeser_rst_n, oLoading, oKey_en, oMsg_en, oSer_bit, oSer_valid,
             oBusy, oDone, oState, oBit_counter
   );
   modport master (
      output iStart, iAbort, iBit_valid, iKey, iMsg, iSer_ready,
      input  oDeser_rst_n, oLoading, oKey_en, oMsg_en, oSer_bit, oSer_valid,
             oBusy, oDone, oState, oBit_counter
   );
endinterface

// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl: sequences clear/key-load/message-load, captures key^msg and streams it out MSB first
module xor_cipher_ctrl #(
   parameter int DATA_SIZE = 32
) (
   input logic           iClk,
   input logic           iRst,
   xor_cipher_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_SIZE) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_SIZE - 1);
   typedef enum logic [2:0] {
      IDLE = 3'd0, CLR = 3'd1, LOAD_KEY = 3'd2, LOAD_MSG = 3'd3,
      ENCRYPT = 3'd4, SHIFT_OUT = 3'd5, DONE = 3'd6
   } state_t;
   state_t               r_state, w_next;
   logic [CNT_W-1:0]     r_cnt, w_cnt;
   logic [DATA_SIZE-1:0] r_result, w_result;
   logic                 w_last, w_xfer, w_abort;
   always_comb begin
      w_last  = r_cnt == LAST;
      w_xfer  = (r_state == SHIFT_OUT) && bus.iSer_ready;
      w_abort = bus.iAbort && (r_state != IDLE) && (r_state != DONE);
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt;
         r_result <= w_result;
      end
   end
   // abort is applied last so it beats a phase-final bit in the same cycle
   always_comb begin
      w_next   = r_state;
      w_cnt    = r_cnt;
      w_result = r_result;
      case (r_state)
         IDLE:     w_next = bus.iStart ? CLR : IDLE;
         CLR: begin
            w_next = LOAD_KEY;
            w_cnt  = '0;
         end
         LOAD_KEY, LOAD_MSG:
            if (bus.iBit_valid) begin
               w_cnt = w_last ? '0 : r_cnt + 1'b1;
               if (w_last) w_next = (r_state == LOAD_KEY) ? LOAD_MSG : ENCRYPT;
            end
         ENCRYPT: begin
            w_result = bus.iKey ^ bus.iMsg;
            w_cnt    = '0;
            w_next   = SHIFT_OUT;
         end
         SHIFT_OUT:
            if (w_xfer) begin
               w_result = {r_result[DATA_SIZE-2:0], 1'b0};
               w_cnt    = r_cnt + 1'b1;
               if (w_last) w_next = DONE;
            end
         default:  w_next = IDLE;
      endcase
      if (w_abort) begin
         w_next = IDLE;
         w_cnt  = '0;
      end
   end
   always_comb begin
      bus.oDeser_rst_n = r_state != CLR;
      bus.oLoading     = (r_state == LOAD_KEY) || (r_state == LOAD_MSG);
      bus.oKey_en      = (r_state == LOAD_KEY) && bus.iBit_valid;
      bus.oMsg_en      = (r_state == LOAD_MSG) && bus.iBit_valid;
      bus.oSer_valid   = r_state == SHIFT_OUT;
      bus.oSer_bit     = (r_state == SHIFT_OUT) && r_result[DATA_SIZE-1];
      bus.oBusy        = r_state != IDLE;
      bus.oDone        = r_state == DONE;
      bus.oState       = r_state;
      bus.oBit_counter = r_cnt;
   end
endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// tb_xor_cipher_ctrl: table-driven transactions plus abort/reset/ignored-start sequences
module tb_xor_cipher_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   xor_cipher_ctrl_if #(.DATA_SIZE(8))  b8();
   xor_cipher_ctrl_if #(.DATA_SIZE(32)) b32();
   xor_cipher_ctrl #(.DATA_SIZE(8))  dut8 (.iClk(clk), .iRst(rst), .bus(b8.slave));
   xor_cipher_ctrl #(.DATA_SIZE(32)) dut32(.iClk(clk), .iRst(rst), .bus(b32.slave));
   // behavioural deserializers for the 8-bit instance: registered, MSB arrives first
   logic       ser_in;
   logic [7:0] k_sr, m_sr;
   always_ff @(posedge clk) begin
      if (!b8.oDeser_rst_n) begin
         k_sr <= '0;
         m_sr <= '0;
      end else begin
         if (b8.oKey_en) k_sr <= {k_sr[6:0], ser_in};
         if (b8.oMsg_en) m_sr <= {m_sr[6:0], ser_in};
      end
   end
   assign b8.iKey = k_sr;
   assign b8.iMsg = m_sr;
   typedef struct {
      logic [7:0] key;
      logic [7:0] msg;
      int         vper;
      bit         tog;
      logic [7:0] exp_res;
      int         exp_done;
   } vec_t;
   vec_t vecs[5];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic chk_rst8(input string name);
      chk(name, {b8.oDeser_rst_n, b8.oLoading, b8.oKey_en, b8.oMsg_en, b8.oSer_bit,
                 b8.oSer_valid, b8.oBusy, b8.oDone, b8.oState, b8.oBit_counter}, 15'h4000);
   endtask
   task automatic run8(input vec_t v);
      int         b = 0, r = 0, nx = 0, kc = 0, mc = 0;
      bit         done_seen = 0, hold_pending = 0;
      logic       held = 1'b0;
      logic [7:0] res = '0;
      logic [15:0] km = {v.key, v.msg};
      b8.iStart = 1'b1;
      tick();
      b8.iStart = 1'b0;
      for (int c = 0; c < 200 && !done_seen; c++) begin
         b8.iBit_valid = (c >= 1) && (b < 16) && (((c - 1) % v.vper) == v.vper - 1);
         ser_in = b8.iBit_valid ? km[15] : 1'b0;
         if (b8.iBit_valid) begin
            km = km << 1;
            b++;
         end
         b8.iSer_ready = v.tog ? (r % 2 == 0) : 1'b1;
         #1;
         if (c == 0) chk("clr_rst_n_low", {b8.oState, b8.oDeser_rst_n}, {3'd1, 1'b0});
         if (c == 1) chk("clr_rst_n_high", {b8.oState, b8.oDeser_rst_n}, {3'd2, 1'b1});
         chk("en_exclusive", b8.oKey_en & b8.oMsg_en, 0);
         if (b8.oKey_en) kc++;
         if (b8.oMsg_en) mc++;
         if (hold_pending) chk("hold_bit", b8.oSer_bit, held);
         hold_pending = 0;
         if (b8.oSer_valid) begin
            if (b8.iSer_ready) begin
               res = {res[6:0], b8.oSer_bit};
               nx++;
            end else begin
               held = b8.oSer_bit;
               hold_pending = 1;
            end
            r++;
         end
         if (b8.oDone) begin
            done_seen = 1;
            chk("done_cycle", c, v.exp_done);
            chk("result", res, v.exp_res);
            chk("transfers", nx, 8);
            chk("done_counter", b8.oBit_counter, 8);
            chk("key_en_count", kc, 8);
            chk("msg_en_count", mc, 8);
         end
         tick();
      end
      if (!done_seen) chk("done_timeout", 0, 1);
      b8.iBit_valid = 1'b0;
      b8.iSer_ready = 1'b0;
      #1 chk("after_done", {b8.oDone, b8.oBusy, b8.oState}, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      logic [31:0] res32;
      logic [3:0]  c0;
      logic        bit0;
      bit          done32;
      vecs[0] = '{8'hA5, 8'h3C, 1, 1'b0, 8'h99, 26};
      vecs[1] = '{8'hA5, 8'h3C, 3, 1'b0, 8'h99, 58};
      vecs[2] = '{8'hA5, 8'h3C, 1, 1'b1, 8'h99, 33};
      vecs[3] = '{8'h0F, 8'hF0, 2, 1'b1, 8'hFF, 49};
      vecs[4] = '{8'h81, 8'h81, 1, 1'b0, 8'h00, 26};
      rst = 1'b1;
      {b8.iStart, b8.iAbort, b8.iBit_valid, b8.iSer_ready} = '0;
      {b32.iStart, b32.iAbort, b32.iBit_valid, b32.iSer_ready} = '0;
      b32.iKey = 32'hFFFF_FFFF;
      b32.iMsg = 32'h1234_5678;
      ser_in = 1'b0;
      tick();
      tick();
      chk_rst8("reset_outputs");
      chk("reset_state32", {b32.oState, b32.oBusy, b32.oDeser_rst_n}, 5'b00001);
      rst = 1'b0;
      tick();
      // abort on the 4th key bit
      b8.iStart = 1'b1;
      tick();
      b8.iStart = 1'b0;
      tick();
      b8.iBit_valid = 1'b1;
      tick();
      tick();
      tick();
      b8.iAbort = 1'b1;
      #1 chk("abort_pre", {b8.oState, b8.oBit_counter, b8.oKey_en}, {3'd2, 4'd3, 1'b1});
      tick();
      b8.iAbort = 1'b0;
      b8.iBit_valid = 1'b0;
      #1 chk("abort_idle", {b8.oState, b8.oBusy, b8.oDone, b8.oBit_counter}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1 chk("abort_no_done", {b8.oDone, b8.oState}, 0);
      end
      for (int i = 0; i < 5; i++) run8(vecs[i]);
      // start ignored in LOAD_KEY, then reset in LOAD_MSG
      tick();
      b8.iStart = 1'b1;
      tick();
      b8.iStart = 1'b0;
      tick();
      b8.iStart = 1'b1;
      tick();
      b8.iStart = 1'b0;
      #1 chk("start_ign_load", b8.oState, 3'd2);
      b8.iBit_valid = 1'b1;
      for (int i = 0; i < 20 && b8.oState != 3'd3; i++) tick();
      #1 chk("reach_load_msg", b8.oState, 3'd3);
      rst = 1'b1;
      b8.iAbort = 1'b1;
      b8.iStart = 1'b1;
      tick();
      rst = 1'b0;
      b8.iAbort = 1'b0;
      b8.iStart = 1'b0;
      b8.iBit_valid = 1'b0;
      #1 chk_rst8("reset_in_load_msg");
      // start ignored in SHIFT_OUT, then reset in SHIFT_OUT
      b8.iStart = 1'b1;
      tick();
      b8.iStart = 1'b0;
      b8.iBit_valid = 1'b1;
      b8.iSer_ready = 1'b1;
      for (int i = 0; i < 40 && !b8.oSer_valid; i++) tick();
      #1 chk("reach_shift", b8.oState, 3'd5);
      tick();
      tick();
      b8.iSer_ready = 1'b0;
      b8.iStart = 1'b1;
      #1;
      c0 = b8.oBit_counter;
      bit0 = b8.oSer_bit;
      tick();
      b8.iStart = 1'b0;
      #1 chk("start_ign_shift", {b8.oState, b8.oBit_counter, b8.oSer_bit}, {3'd5, c0, bit0});
      chk("shift_counter_mid", c0, 4'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b8.iBit_valid = 1'b0;
      #1 chk_rst8("reset_in_shift");
      // 32-bit instance
      res32 = '0;
      done32 = 0;
      b32.iStart = 1'b1;
      tick();
      b32.iStart = 1'b0;
      b32.iBit_valid = 1'b1;
      b32.iSer_ready = 1'b1;
      for (int i = 0; i < 200 && !done32; i++) begin
         #1;
         if (b32.oSer_valid) res32 = {res32[30:0], b32.oSer_bit};
         if (b32.oDone) begin
            done32 = 1;
            chk("done_cycle32", i, 1 + 32 + 32 + 1 + 32);
            chk("result32", res32, 32'hEDCB_A987);
            chk("counter32", b32.oBit_counter, 32);
         end
         tick();
      end
      if (!done32) chk("done_timeout32", 0, 1);
      b32.iBit_valid = 1'b0;
      #1 chk("after_done32", {b32.oDone, b32.oState}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/xor_cipher_ctrl.md
Name: xor_cipher_ctrl

Overview:
Sequencer for one XOR-cipher transaction. It drives two external deserializer instances, one for the key and one for the message, through clear, key-load and message-load phases. It then captures key XOR message and streams the result out serially, MSB first, with a valid/ready handshake. It sits between the chip-level serial pins and the deserializer datapath.

Parameters:
DATA_SIZE, 32, word width of key, message and result; must be >= 2
CNT_W, $clog2(DATA_SIZE)+1, width of the bit counter (derived, not overridden)

Ports:
iClk  input  1  system clock; all state changes on rising edge
iRst  input  1  synchronous, active-high reset
iStart  input  1  start transaction; sampled only in IDLE
iAbort  input  1  cancel the transaction in progress
iBit_valid  input  1  serial input bit present this cycle (bit itself goes straight to the deserializers)
iKey  input  DATA_SIZE  parallel output of the key deserializer
iMsg  input  DATA_SIZE  parallel output of the message deserializer
iSer_ready  input  1  downstream accepts oSer_bit this cycle
oDeser_rst_n  output  1  active-low clear to both deserializers
oLoading  output  1  loading-mode flag to both deserializers
oKey_en  output  1  shift enable, key deserializer
oMsg_en  output  1  shift enable, message deserializer
oSer_bit  output  1  current result bit
oSer_valid  output  1  oSer_bit valid
oBusy  output  1  high in every state except IDLE
oDone  output  1  one-cycle pulse at end of a successful transaction
oState  output  3  encoded state, for debug
oBit_counter  output  CNT_W  bits counted in the current phase

Behaviour:
- Reset: iRst high at a clock edge gives state IDLE, counter 0, result register 0. Outputs after reset: oDeser_rst_n=1, all other outputs 0. Reset overrides iAbort and iStart.
- State encoding: IDLE=0, CLR=1, LOAD_KEY=2, LOAD_MSG=3, ENCRYPT=4, SHIFT_OUT=5, DONE=6.
- IDLE: iStart=1 moves to CLR next cycle; iStart in any other state is ignored.
- CLR: exactly one cycle. oDeser_rst_n=0, counter cleared, then LOAD_KEY.
- LOAD_KEY:
  - oLoading=1; oKey_en=iBit_valid (combinational).
  - Counter increments on each iBit_valid.
  - When iBit_valid=1 and counter==DATA_SIZE-1: go to LOAD_MSG and clear the counter.
  - Gaps in iBit_valid are allowed: no timeout, state holds.
- LOAD_MSG: same rules as LOAD_KEY, using oMsg_en; exits to ENCRYPT.
- ENCRYPT: exactly one cycle, oLoading=0. The deserializer output is registered, so iMsg already holds its last bit here. Capture result = iKey ^ iMsg, clear the counter, go to SHIFT_OUT.
- SHIFT_OUT:
  - oSer_valid=1; oSer_bit = result[DATA_SIZE-1].
  - On oSer_valid && iSer_ready: shift result left by 1 with zero fill, and increment the counter.
  - When the transfer with counter==DATA_SIZE-1 completes, go to DONE.
  - Without ready, oSer_bit and oSer_valid hold stable.
- DONE: oDone=1 for one cycle, then IDLE. The counter keeps DATA_SIZE while in DONE; it clears on the next CLR.
- oKey_en/oMsg_en: never both high; always 0 outside their load state.
- iAbort=1 in any state other than IDLE/DONE: go to IDLE next cycle, no oDone, counter cleared. iAbort in the same cycle as a phase-final bit still wins.
- oBit_counter: equals the internal counter and never exceeds DATA_SIZE.
- Reset mid-operation (any state): IDLE next cycle, with outputs at reset values.

Test Plan:
- DATA_SIZE=8, key 0xA5 then msg 0x3C, iBit_valid continuous, iSer_ready=1 → result 0x99 out as 1,0,0,1,1,0,0,1. oDone pulses once 1+8+8+1+8 = 26 cycles after the CLR cycle is entered.
- DATA_SIZE=8, iBit_valid asserted every 3rd cycle during loads → same 0x99 output. oKey_en high only on valid cycles; state stays LOAD_KEY through the gaps.
- iSer_ready toggling 1,0,1,0 during SHIFT_OUT → oSer_bit holds while ready=0. Exactly 8 transfers, then oDone.
- iAbort on the 4th key bit → IDLE next cycle, oBusy=0, no oDone. A fresh iStart then runs a full transaction correctly, with CLR asserting oDeser_rst_n=0 for 1 cycle.
- iRst asserted during LOAD_MSG and during SHIFT_OUT → next cycle oState=0, all outputs 0 except oDeser_rst_n=1. iStart pulses in LOAD_KEY and SHIFT_OUT → ignored, no restart.
- DATA_SIZE=32, key 0xFFFFFFFF, msg 0x12345678 → serial output 0xEDCBA987. oBit_counter reads 32 in DONE.
